// File: rtl/spi_target.sv
// spi_target: SPI mode-0 (CPOL=0, CPHA=0) responder oversampled on cclk.
//  Receives frames of up to MAXBITS bits and returns a preloaded reply on miso.
//  Bit order is LSB-first by default; define SPI_TARGET_MSB_FIRST_EN for MSB-first.
// Ports:
//  cclk, rst              system clock, synchronous active-high reset
//  ss_n, sclk, mosi       asynchronous SPI inputs from the initiator
//  miso, miso_oe          serial reply and its pad output enable
//  tx_data/valid/ready    reply frame handshake into a one-entry holding register
//  rx_data/len/valid/trunc last completed frame, bit count, update pulse, overflow flag
//  busy                   frame in progress
module spi_target #(
  parameter int MAXBITS = 80,
  parameter int SYNC_STAGES = 2,
  localparam int LW = $clog2(MAXBITS + 1)
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [MAXBITS-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [MAXBITS-1:0] rx_data,
  output logic [LW-1:0]      rx_len,
  output logic               rx_valid,
  output logic               rx_trunc,
  output logic               busy
);
`ifdef SPI_TARGET_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] ss_q, sclk_q, mosi_q;
  logic [SYNC_STAGES:0] prime;
  logic ss_p, sclk_p, hold_full, trunc;
  logic [MAXBITS-1:0] hold, tx_sh, rx_sh, tx_next, rx_next, tx_load;
  logic [LW-1:0] bitcnt;
  logic ss_s, sclk_s, mosi_s, settled, ss_fall, ss_rise, sclk_rise, sclk_fall;
  always_comb begin
    ss_s = ss_q[SYNC_STAGES-1];
    sclk_s = sclk_q[SYNC_STAGES-1];
    mosi_s = mosi_q[SYNC_STAGES-1];
    // the synchroniser resets to 1, so its output only reflects the real pin once
    // the reset value has been flushed through every stage and the edge-detect flop
    settled = prime[SYNC_STAGES];
    ss_fall = ss_p && !ss_s;
    ss_rise = !ss_p && ss_s;
    sclk_rise = !sclk_p && sclk_s;
    sclk_fall = sclk_p && !sclk_s;
    tx_load = hold_full ? hold : '1;
    // ones are shifted in behind the reply so miso idles high once it is exhausted
    tx_next = MSB ? {tx_sh[MAXBITS-2:0], 1'b1} : {1'b1, tx_sh[MAXBITS-1:1]};
    rx_next = MSB ? {rx_sh[MAXBITS-2:0], mosi_s} : rx_sh | (MAXBITS'(mosi_s) << bitcnt);
  end
  assign tx_ready = !hold_full;
  assign busy = state == ACTIVE;
  always_ff @(posedge cclk) begin
    if (rst) begin
      ss_q <= '1;
      sclk_q <= '1;
      mosi_q <= '1;
      ss_p <= 1'b1;
      sclk_p <= 1'b1;
      prime <= '0;
      state <= WAIT_HIGH;
      hold <= '0;
      hold_full <= 1'b0;
      tx_sh <= '1;
      rx_sh <= '0;
      bitcnt <= '0;
      trunc <= 1'b0;
      miso <= 1'b1;
      miso_oe <= 1'b0;
      rx_data <= '0;
      rx_len <= '0;
      rx_valid <= 1'b0;
      rx_trunc <= 1'b0;
    end else begin
      ss_q <= {ss_q[SYNC_STAGES-2:0], ss_n};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_p <= ss_s;
      sclk_p <= sclk_s;
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      rx_valid <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        WAIT_HIGH: if (settled && ss_s) state <= IDLE;
        IDLE: if (ss_fall) begin
          state <= ACTIVE;
          bitcnt <= '0;
          rx_sh <= '0;
          trunc <= 1'b0;
          tx_sh <= tx_load;
          miso <= MSB ? tx_load[MAXBITS-1] : tx_load[0];
          miso_oe <= 1'b1;
          // a full holding reg blocks acceptance this cycle, so clearing it cannot race a capture
          if (hold_full) hold_full <= 1'b0;
        end
        ACTIVE: if (ss_rise) begin
          state <= IDLE;
          miso_oe <= 1'b0;
          miso <= 1'b1;
          if (bitcnt != '0) begin
            rx_data <= rx_sh;
            rx_len <= bitcnt;
            rx_trunc <= trunc;
            rx_valid <= 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            if (bitcnt < LW'(MAXBITS)) begin
              rx_sh <= rx_next;
              bitcnt <= bitcnt + 1'b1;
            end else trunc <= 1'b1;
          end
          if (sclk_fall) begin
            tx_sh <= tx_next;
            miso <= MSB ? tx_next[MAXBITS-1] : tx_next[0];
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: scoreboard bench for spi_target driving an SPI mode-0 initiator at sclk = cclk/8
module tb_spi_target;
`ifdef SPI_TARGET_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam int LW = 7;
  typedef struct packed {
    logic [79:0] d;
    logic [LW-1:0] l;
    logic t;
  } exp_t;
  logic cclk = 1'b0, rst = 1'b1, ss_n = 1'b1, sclk = 1'b0, mosi = 1'b0, tx_valid = 1'b0;
  logic [79:0] tx_data = '0;
  logic miso, miso_oe, tx_ready, rx_valid, rx_trunc, busy;
  logic [79:0] rx_data;
  logic [LW-1:0] rx_len;
  int checks = 0, failures = 0, npulse = 0, p0;
  exp_t sb[$];
  exp_t e;
  logic [127:0] mo, seq;
  logic [79:0] last_d;
  spi_target dut (
    .cclk(cclk), .rst(rst), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_len(rx_len), .rx_valid(rx_valid),
    .rx_trunc(rx_trunc), .busy(busy)
  );
  always #5 cclk = ~cclk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  always @(negedge cclk) if (rx_valid === 1'b1) begin
    npulse++;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rx_unexpected actual=%h/%0d required=no pulse", rx_data, rx_len);
    end else begin
      e = sb.pop_front();
      chk("rx_data", rx_data, e.d);
      chk("rx_len", rx_len, e.l);
      chk("rx_trunc", rx_trunc, e.t);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge cclk);
  endtask
  function automatic logic [127:0] wire_of(input logic [127:0] v, input int n);
    logic [127:0] r = v;
    if (MSB) for (int k = 0; k < n; k++) r[k] = v[n-1-k];
    return r;
  endfunction
  function automatic logic [79:0] exp_rx(input logic [127:0] s, input int n);
    logic [79:0] r = '0;
    int m = n > 80 ? 80 : n;
    for (int k = 0; k < m; k++) if (MSB) r[m-1-k] = s[k]; else r[k] = s[k];
    return r;
  endfunction
  function automatic logic [127:0] exp_miso(input logic [79:0] tx, input bit has, input int n);
    logic [127:0] r = '1;
    for (int k = 0; k < n && k < 80; k++) if (has) r[k] = MSB ? tx[79-k] : tx[k];
    return r;
  endfunction
  task automatic offer(input logic [79:0] v);
    tx_data = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask
  task automatic clock_bits(input logic [127:0] s, input int n, output logic [127:0] m);
    m = '1;
    for (int k = 0; k < n; k++) begin
      sclk = 1'b0;
      mosi = s[k];
      cyc(4);
      m[k] = miso;
      sclk = 1'b1;
      cyc(4);
    end
    sclk = 1'b0;
    cyc(4);
  endtask
  task automatic frame(input logic [127:0] s, input int n, output logic [127:0] m);
    ss_n = 1'b0;
    cyc(8);
    clock_bits(s, n, m);
    ss_n = 1'b1;
    cyc(10);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(3);
    chk("rst_miso", miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_len", rx_len, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_trunc", rx_trunc, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc(8);
    offer(80'hA5);
    chk("t2_tx_ready_low", tx_ready, 0);
    sb.push_back('{d: 80'h3C, l: 7'd8, t: 1'b0});
    ss_n = 1'b0;
    cyc(8);
    chk("t2_busy", busy, 1);
    chk("t2_miso_oe", miso_oe, 1);
    chk("t2_tx_ready_back", tx_ready, 1);
    clock_bits(wire_of(128'h3C, 8), 8, mo);
    ss_n = 1'b1;
    cyc(10);
    chk("t2_miso", mo, exp_miso(80'hA5, 1'b1, 8));
    if (!MSB) chk("t2_miso_hand", mo[7:0], 8'hA5);
    chk("t2_miso_oe_off", miso_oe, 0);
    chk("t2_busy_off", busy, 0);
    sb.push_back('{d: 80'hB, l: 7'd4, t: 1'b0});
    frame(wire_of(128'hB, 4), 4, mo);
    chk("t3_miso", mo, exp_miso(80'h0, 1'b0, 4));
    chk("t3_tx_ready", tx_ready, 1);
    offer(80'h0);
    seq = 128'h3_1234_5678_9ABC_DEF0_1357;
    last_d = exp_rx(seq, 82);
    sb.push_back('{d: last_d, l: 7'd80, t: 1'b1});
    frame(seq, 82, mo);
    chk("t4_miso", mo, exp_miso(80'h0, 1'b1, 82));
    chk("t4_miso_80_81", mo[81:80], 2'b11);
    p0 = npulse;
    ss_n = 1'b0;
    cyc(12);
    ss_n = 1'b1;
    cyc(12);
    chk("t5_no_pulse", npulse - p0, 0);
    chk("t5_rx_data_held", rx_data, last_d);
    chk("t5_rx_len_held", rx_len, 80);
    chk("t5_rx_trunc_held", rx_trunc, 1);
    p0 = npulse;
    ss_n = 1'b0;
    cyc(8);
    offer(80'h1234);
    chk("t6_tx_ready_low", tx_ready, 0);
    clock_bits(128'b10110, 5, mo);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_tx_ready_cleared", tx_ready, 1);
    clock_bits(128'b101, 3, mo);
    chk("t6_busy_still_low", busy, 0);
    chk("t6_no_pulse", npulse - p0, 0);
    ss_n = 1'b1;
    cyc(8);
    sb.push_back('{d: 80'h6, l: 7'd4, t: 1'b0});
    frame(wire_of(128'h6, 4), 4, mo);
    chk("t6_next_frame_miso", mo, exp_miso(80'h0, 1'b0, 4));
    chk("t6_next_frame_pulse", npulse - p0, 1);
`ifdef SPI_TARGET_MSB_FIRST_EN
    offer(80'h8000_0000_0000_0000_0001);
    sb.push_back('{d: 80'h3C, l: 7'd8, t: 1'b0});
    frame(wire_of(128'h3C, 8), 8, mo);
    chk("t7_miso", mo[7:0], 8'h01);
`endif
    cyc(20);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
